// File: rtl/univ_shreg.sv
// Universal shift register: load, shift, rotate and clear, with a saturating shift counter.
// Define UNIV_SHREG_PARITY_EN to add a registered even-parity output (par).
module univ_shreg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic [7:0]       cnt
`ifdef UNIV_SHREG_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_HOLD2 = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_s;

    assign mode_s = mode_e'(mode);

    // Next-state decode; every shift/rotate moves one bit out through sout.
    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        shift_s = 1'b0;
        if (en) begin
            case (mode_s)
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], sin_l};
                    sout_d  = q_q[WIDTH-1];
                    shift_s = 1'b1;
                end
                MODE_SHR: begin
                    q_d     = {sin_r, q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    shift_s = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d  = q_q[WIDTH-1];
                    shift_s = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    shift_s = 1'b1;
                end
                MODE_CLEAR: begin
                    q_d   = RST_VAL;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        if (shift_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_VAL;
            sout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q    = q_q;
    assign qb   = ~q_q;
    assign sout = sout_q;
    assign cnt  = cnt_q;

`ifdef UNIV_SHREG_PARITY_EN
    logic par_q;

    // Parity tracks the value q is about to take, so it lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= ^RST_VAL;
        end else begin
            par_q <= ^q_d;
        end
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb_univ_shreg.sv
// Scoreboard bench for univ_shreg (WIDTH=8, RST_VAL=8'hA5) against an arithmetic reference model.
module tb_univ_shreg;

    localparam int unsigned W    = 8;
    localparam logic [7:0]  RV   = 8'hA5;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l, sin_r;
    logic [W-1:0] q, qb;
    logic         sout;
    logic [7:0]   cnt;
`ifdef UNIV_SHREG_PARITY_EN
    logic         par;
`endif

    univ_shreg #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .q     (q),
        .qb    (qb),
        .sout  (sout),
        .cnt   (cnt)
`ifdef UNIV_SHREG_PARITY_EN
        ,
        .par   (par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        longint unsigned q;
        bit             sout;
        int             cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model state
    longint unsigned mq;
    bit              msout;
    int              mcnt;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq    = RV;
        msout = 1'b0;
        mcnt  = 0;
    endfunction

    function automatic void model_step(input bit e, input int m, input longint unsigned dv,
                                       input bit sl, input bit sr);
        bit shifted = 1'b0;
        if (!e) return;
        case (m)
            1: begin mq = dv & MASK; mcnt = 0; end
            2: begin msout = bit'((mq >> (W-1)) & 1); mq = ((mq * 2) + sl) & MASK; shifted = 1; end
            3: begin msout = bit'(mq & 1); mq = (mq / 2) + (longint'(sr) << (W-1)); shifted = 1; end
            4: begin msout = bit'((mq >> (W-1)) & 1); mq = ((mq * 2) + (mq >> (W-1))) & MASK; shifted = 1; end
            5: begin msout = bit'(mq & 1); mq = (mq / 2) + ((mq & 1) << (W-1)); shifted = 1; end
            6: begin mq = RV; mcnt = 0; end
            default: ;
        endcase
        if (shifted && mcnt < 255) mcnt++;
    endfunction

    // Drive one operation at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit e, input int m, input logic [W-1:0] dv, input bit sl, input bit sr);
        exp_t x;
        @(negedge clk);
        en = e; mode = 3'(m); d = dv; sin_l = sl; sin_r = sr;
        model_step(e, m, longint'(dv), sl, sr);
        step_id++;
        x.id = step_id; x.q = mq; x.sout = msout; x.cnt = mcnt;
        exp_q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: every rising edge out of reset presents a new state to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("sb_q[%0d]", e.id), longint'(q), e.q);
                chk($sformatf("sb_qb[%0d]", e.id), longint'(qb), (~e.q) & MASK);
                chk($sformatf("sb_sout[%0d]", e.id), longint'(sout), longint'(e.sout));
                chk($sformatf("sb_cnt[%0d]", e.id), longint'(cnt), longint'(e.cnt));
`ifdef UNIV_SHREG_PARITY_EN
                chk($sformatf("sb_par[%0d]", e.id), longint'(par), longint'(^(e.q[W-1:0])));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] shl_bits;
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        model_reset();
        #3;
        chk("rst0_q", longint'(q), 64'hA5);
        chk("rst0_qb", longint'(qb), 64'h5A);
        chk("rst0_cnt", longint'(cnt), 0);
        chk("rst0_sout", longint'(sout), 0);
        release_rst();

        // LOAD then SHL
        step(1, 1, 8'h81, 0, 0);
        step(1, 2, 8'h00, 0, 0);
        settle();
        chk("shl_q", longint'(q), 64'h02);
        chk("shl_sout", longint'(sout), 1);
        chk("shl_cnt", longint'(cnt), 1);

        // Rotate wrap with ROR
        step(1, 1, 8'h96, 0, 0);
        step(1, 5, 8'h00, 1, 1);
        settle();
        chk("ror1_sout", longint'(sout), 0);
        for (int i = 0; i < 7; i++) step(1, 5, 8'hFF, 1, 1);
        settle();
        chk("ror8_q", longint'(q), 64'h96);
        chk("ror8_cnt", longint'(cnt), 8);

        // ROL wrap
        step(1, 1, 8'h4D, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 4, 8'h00, 0, 0);
        settle();
        chk("rol8_q", longint'(q), 64'h4D);

        // Enable gating; sout must keep its last shifted value
        step(1, 1, 8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 3, 8'hFF, 1, 1);
        settle();
        chk("gate_q", longint'(q), 64'h3C);
        chk("gate_cnt", longint'(cnt), 0);
        chk("gate_sout", longint'(sout), 1);

        // SHL fill: q holds the sampled sin_l bits, first sample at MSB
        shl_bits = 8'b1011_0010;
        step(1, 1, 8'h5A, 0, 0);
        for (int i = 7; i >= 0; i--) step(1, 2, 8'h00, shl_bits[i], 0);
        settle();
        chk("shl8_q", longint'(q), 64'hB2);

        // Count saturation then CLEAR
        for (int i = 0; i < 300; i++) step(1, 2, 8'h00, 1'($urandom), 0);
        settle();
        chk("sat_cnt", longint'(cnt), 255);
        step(1, 6, 8'h00, 0, 0);
        settle();
        chk("clr_q", longint'(q), 64'hA5);
        chk("clr_cnt", longint'(cnt), 0);

        // Reset in the middle of a ROL burst, between clock edges
        step(1, 1, 8'hC3, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4, 8'h00, 0, 0);
        settle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_q", longint'(q), 64'hA5);
        chk("midrst_qb", longint'(qb), 64'h5A);
        chk("midrst_cnt", longint'(cnt), 0);
        chk("midrst_sout", longint'(sout), 0);
`ifdef UNIV_SHREG_PARITY_EN
        chk("midrst_par", longint'(par), 0);
`endif
        repeat (2) @(posedge clk);
        release_rst();
        // First edge after release must act
        step(1, 1, 8'h07, 0, 0);
        settle();
        chk("post_rst_q", longint'(q), 64'h07);
`ifdef UNIV_SHREG_PARITY_EN
        chk("post_rst_par", longint'(par), 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shreg.md
UNIV_SHREG -- requirements
Module: univ_shreg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, range 2..64.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset and by the CLEAR mode.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  synchronous enable; when 0, all state holds regardless of mode.
REQ-006 mode  input  3  operation select, per REQ-011.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin_l  input  1  serial input entering at the LSB on shift left.
REQ-009 sin_r  input  1  serial input entering at the MSB on shift right.
REQ-010 Outputs, one per line:
- q  output  WIDTH  registered state.
- qb  output  WIDTH  ~q, combinational.
- sout  output  1  bit shifted out by the last shift or rotate, registered.
- cnt  output  8  shifts since the last load or clear, saturating at 255.

Function
REQ-011 The mode encoding SHALL be applied only when en=1:
- 000 HOLD.
- 001 LOAD: q<=d.
- 010 SHL: q<={q[W-2:0],sin_l}, sout<=q[W-1].
- 011 SHR: q<={sin_r,q[W-1:1]}, sout<=q[0].
- 100 ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
- 101 ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
- 110 CLEAR: q<=RST_VAL.
- 111 HOLD.
REQ-012 Latency SHALL be exactly one clock from a sampled en/mode/d/serial input to the updated q.
REQ-013 sout SHALL change only on modes 010-101 with en=1 and otherwise hold its value.
REQ-014 cnt SHALL be set to 0 on LOAD or CLEAR, increment by 1 on each enabled shift or rotate, saturate at 255, and hold in HOLD or when en=0.
REQ-015 After WIDTH consecutive ROL operations, or WIDTH consecutive ROR operations, q SHALL equal its starting value.
REQ-016 After WIDTH consecutive SHL operations, q SHALL consist entirely of the sin_l bits sampled during those operations, in sample order from MSB down to LSB.
REQ-017 The first rising clk edge after rst deasserts SHALL be processed normally: no dead cycle and no lost operation.

Reset
REQ-018 While rst=1: q=RST_VAL, qb=~RST_VAL, sout=0, cnt=0, applied immediately without waiting for clk.
REQ-019 rst asserted mid-sequence SHALL abandon any operation in progress; no partial shift or rotate result SHALL survive reset.
REQ-020 rst SHALL take priority over en and every mode.

Configuration
REQ-021 Macro UNIV_SHREG_PARITY_EN, when defined, SHALL add output port par (1 bit, even parity).
- par is registered and updated together with q, equal to ^q_next.
- Reset value of par is ^RST_VAL.
REQ-022 When UNIV_SHREG_PARITY_EN is not defined, port par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Reset check, WIDTH=8, RST_VAL=8'hA5: assert rst between clk edges -> q=8'hA5, qb=8'h5A, cnt=0 with no clk edge needed.
REQ-024 LOAD, then SHL: LOAD d=8'h81, then SHL with sin_l=0 -> q=8'h02, sout=1, cnt=1.
REQ-025 Rotate wrap: LOAD 8'h96, then 8 x ROR -> q=8'h96, cnt=8; sout after the first ROR = 0.
REQ-026 Enable gating: LOAD 8'h3C, then en=0 with mode=SHR for 5 clocks -> q=8'h3C, cnt=0, sout unchanged.
REQ-027 Count saturation, then clear:
- 300 x SHL -> cnt=255.
- CLEAR -> q=RST_VAL, cnt=0.
REQ-028 Mid-operation reset with UNIV_SHREG_PARITY_EN defined: assert rst during a ROL burst -> q=RST_VAL, par=^RST_VAL, cnt=0; the first post-reset LOAD 8'h07 -> par=1.
